// File: rtl/wots_pk_from_sig.sv
// WOTS public-key recovery: completes each signature chain from its digit up to W-1 via gen_chain.
// Optional build macro WOTS_PK_FROM_SIG_BYPASS_EN: chains whose digit is already W-1 skip gen_chain.
module wots_pk_from_sig #(
  parameter int unsigned WOTS_W     = 16,
  parameter int unsigned WOTS_LEN   = 67,
  parameter int unsigned WOTS_LEN1  = 64,
  parameter int unsigned WOTS_LEN2  = 3,
  parameter int unsigned KEY_LEN    = 256,
  parameter int unsigned WOTS_LOG_W = $clog2(WOTS_W)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  input  logic [KEY_LEN-1:0]          msg,
  input  logic [KEY_LEN-1:0]          pub_seed,
  input  logic [255:0]                hash_addr,
  output logic                        busy,
  output logic                        done,
  output logic [255:0]                hash_addr_out,
  output logic                        sig_mem_rd_en,
  output logic [$clog2(WOTS_LEN)-1:0] sig_mem_rd_addr,
  input  logic [KEY_LEN-1:0]          sig_mem_dout,
  output logic                        pk_wr_en,
  output logic [$clog2(WOTS_LEN)-1:0] pk_wr_addr,
  output logic [KEY_LEN-1:0]          pk_wr_data,
  output logic                        gen_chain_start,
  output logic [KEY_LEN-1:0]          gen_chain_input_key,
  output logic [KEY_LEN-1:0]          gen_chain_input_data,
  output logic [WOTS_LOG_W-1:0]       gen_chain_start_step,
  output logic [WOTS_LOG_W-1:0]       gen_chain_end_step,
  output logic [255:0]                gen_chain_hash_addr,
  input  logic [KEY_LEN-1:0]          gen_chain_data_out,
  input  logic                        gen_chain_done,
  input  logic                        gen_chain_busy,
  input  logic [255:0]                gen_chain_hash_addr_updated
);

  localparam int unsigned IdxW     = $clog2(WOTS_LEN);
  localparam int unsigned CsumW    = $clog2(WOTS_LEN1 * (WOTS_W - 1) + 1);
  localparam int unsigned CsumDigW = WOTS_LEN2 * WOTS_LOG_W;
  localparam logic [IdxW-1:0]       LastIdx  = IdxW'(WOTS_LEN - 1);
  localparam logic [WOTS_LOG_W-1:0] MaxDigit = WOTS_LOG_W'(WOTS_W - 1);

  typedef enum logic [2:0] {StIdle, StRd, StLoad, StLaunch, StWait, StWrite, StFin} state_e;

  state_e               state_q, state_d;
  logic [IdxW-1:0]      idx_q, idx_d;
  logic [CsumW-1:0]     csum_q, csum_d;
  logic [KEY_LEN-1:0]   msg_q, msg_d;
  logic [255:0]         adrs_q, adrs_d;

  logic                  busy_q, busy_d, done_q, done_d;
  logic                  rd_en_q, rd_en_d, wr_en_q, wr_en_d, gc_start_q, gc_start_d;
  logic [IdxW-1:0]       rd_addr_q, rd_addr_d, wr_addr_q, wr_addr_d;
  logic [KEY_LEN-1:0]    wr_data_q, wr_data_d, gc_data_q, gc_data_d;
  logic [WOTS_LOG_W-1:0] gc_sstep_q, gc_sstep_d, gc_estep_q, gc_estep_d;
  logic [255:0]          gc_adrs_q, gc_adrs_d, adrs_out_q, adrs_out_d;

  logic                  is_msg_digit;
  logic [IdxW-1:0]       chk_idx;
  logic [CsumDigW-1:0]   csum_ext, csum_shifted;
  logic [WOTS_LOG_W-1:0] digit;
  logic [255:0]          chain_adrs;
  logic                  skip_chain;

  // Message digits come MSB-first off a shifting copy; checksum digits MSB-first from the sum.
  always_comb begin
    is_msg_digit = idx_q < IdxW'(WOTS_LEN1);
    chk_idx      = idx_q - IdxW'(WOTS_LEN1);
    csum_ext     = CsumDigW'(csum_q);
    csum_shifted = csum_ext >> (WOTS_LOG_W * (WOTS_LEN2 - 1 - 32'(chk_idx)));
    digit        = is_msg_digit ? msg_q[KEY_LEN-1 -: WOTS_LOG_W] : csum_shifted[WOTS_LOG_W-1:0];
    chain_adrs          = adrs_q;
    chain_adrs[95:64]   = 32'(idx_q);
  end

`ifdef WOTS_PK_FROM_SIG_BYPASS_EN
  assign skip_chain = (digit == MaxDigit);
`else
  assign skip_chain = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= StIdle;
      idx_q      <= '0;
      csum_q     <= '0;
      msg_q      <= '0;
      adrs_q     <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      rd_en_q    <= 1'b0;
      wr_en_q    <= 1'b0;
      gc_start_q <= 1'b0;
      rd_addr_q  <= '0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      gc_data_q  <= '0;
      gc_sstep_q <= '0;
      gc_estep_q <= '0;
      gc_adrs_q  <= '0;
      adrs_out_q <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      csum_q     <= csum_d;
      msg_q      <= msg_d;
      adrs_q     <= adrs_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      rd_en_q    <= rd_en_d;
      wr_en_q    <= wr_en_d;
      gc_start_q <= gc_start_d;
      rd_addr_q  <= rd_addr_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      gc_data_q  <= gc_data_d;
      gc_sstep_q <= gc_sstep_d;
      gc_estep_q <= gc_estep_d;
      gc_adrs_q  <= gc_adrs_d;
      adrs_out_q <= adrs_out_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:   if (start) state_d = StRd;
      StRd:     state_d = StLoad;
      StLoad:   state_d = skip_chain ? StWrite : StLaunch;
      StLaunch: state_d = StWait;
      StWait:   if (gen_chain_done) state_d = StWrite;
      StWrite:  state_d = (idx_q == LastIdx) ? StFin : StRd;
      StFin:    state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // Outputs are registered: strobes follow the state being entered.
  always_comb begin
    idx_d      = idx_q;
    csum_d     = csum_q;
    msg_d      = msg_q;
    adrs_d     = adrs_q;
    rd_addr_d  = rd_addr_q;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    gc_data_d  = gc_data_q;
    gc_sstep_d = gc_sstep_q;
    gc_estep_d = gc_estep_q;
    gc_adrs_d  = gc_adrs_q;
    adrs_out_d = adrs_out_q;
    busy_d     = state_d inside {StRd, StLoad, StLaunch, StWait, StWrite};
    done_d     = (state_d == StFin);
    rd_en_d    = (state_d == StRd);
    wr_en_d    = (state_d == StWrite);
    gc_start_d = (state_d == StLaunch);
    case (state_q)
      StIdle: begin
        if (start) begin
          msg_d  = msg;
          adrs_d = hash_addr;
          idx_d  = '0;
          csum_d = '0;
        end
      end
      StLoad: begin
        gc_data_d  = sig_mem_dout;
        gc_sstep_d = digit;
        gc_estep_d = MaxDigit;
        gc_adrs_d  = chain_adrs;
        if (skip_chain) wr_data_d = sig_mem_dout;
        if (is_msg_digit) begin
          csum_d = csum_q + CsumW'(MaxDigit - digit);
          msg_d  = msg_q << WOTS_LOG_W;
        end
      end
      StWait: begin
        if (gen_chain_done) begin
          wr_data_d  = gen_chain_data_out;
          adrs_out_d = gen_chain_hash_addr_updated;
        end
      end
      StWrite: begin
        if (idx_q != LastIdx) idx_d = idx_q + IdxW'(1);
      end
      default: ;
    endcase
    if (state_d == StRd) rd_addr_d = idx_d;
    if (state_d == StWrite) wr_addr_d = idx_q;
  end

  // A new element is only fetched once the previous chain has fully retired.
  assert property (@(posedge clk) disable iff (!reset) (state_q == StRd) |-> !gen_chain_busy);

  assign busy                 = busy_q;
  assign done                 = done_q;
  assign hash_addr_out        = adrs_out_q;
  assign sig_mem_rd_en        = rd_en_q;
  assign sig_mem_rd_addr      = rd_addr_q;
  assign pk_wr_en             = wr_en_q;
  assign pk_wr_addr           = wr_addr_q;
  assign pk_wr_data           = wr_data_q;
  assign gen_chain_start      = gc_start_q;
  assign gen_chain_input_key  = pub_seed;
  assign gen_chain_input_data = gc_data_q;
  assign gen_chain_start_step = gc_sstep_q;
  assign gen_chain_end_step   = gc_estep_q;
  assign gen_chain_hash_addr  = gc_adrs_q;

endmodule

// File: tb/tb_wots_pk_from_sig.sv
// Bench for wots_pk_from_sig: random signatures/messages against a digit/checksum reference model,
// with a behavioural gen_chain of random latency and a signature memory.
module tb_wots_pk_from_sig;
  localparam int Len = 67;
`ifdef WOTS_PK_FROM_SIG_BYPASS_EN
  localparam bit Bypass = 1'b1;
`else
  localparam bit Bypass = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic start = 1'b0;
  logic [255:0] msg = '0;
  logic [255:0] pub_seed = '0;
  logic [255:0] hash_addr = '0;
  logic busy, done;
  logic [255:0] hash_addr_out;
  logic sig_mem_rd_en;
  logic [6:0] sig_mem_rd_addr;
  logic [255:0] sig_mem_dout = '0;
  logic pk_wr_en;
  logic [6:0] pk_wr_addr;
  logic [255:0] pk_wr_data;
  logic gen_chain_start;
  logic [255:0] gen_chain_input_key, gen_chain_input_data, gen_chain_hash_addr;
  logic [3:0] gen_chain_start_step, gen_chain_end_step;
  logic [255:0] gen_chain_data_out = '0;
  logic gen_chain_done = 1'b0;
  logic gen_chain_busy = 1'b0;
  logic [255:0] gen_chain_hash_addr_updated = '0;

  always #5 clk = ~clk;

  wots_pk_from_sig dut (
    .clk                         (clk),
    .reset                       (reset),
    .start                       (start),
    .msg                         (msg),
    .pub_seed                    (pub_seed),
    .hash_addr                   (hash_addr),
    .busy                        (busy),
    .done                        (done),
    .hash_addr_out               (hash_addr_out),
    .sig_mem_rd_en               (sig_mem_rd_en),
    .sig_mem_rd_addr             (sig_mem_rd_addr),
    .sig_mem_dout                (sig_mem_dout),
    .pk_wr_en                    (pk_wr_en),
    .pk_wr_addr                  (pk_wr_addr),
    .pk_wr_data                  (pk_wr_data),
    .gen_chain_start             (gen_chain_start),
    .gen_chain_input_key         (gen_chain_input_key),
    .gen_chain_input_data        (gen_chain_input_data),
    .gen_chain_start_step        (gen_chain_start_step),
    .gen_chain_end_step          (gen_chain_end_step),
    .gen_chain_hash_addr         (gen_chain_hash_addr),
    .gen_chain_data_out          (gen_chain_data_out),
    .gen_chain_done              (gen_chain_done),
    .gen_chain_busy              (gen_chain_busy),
    .gen_chain_hash_addr_updated (gen_chain_hash_addr_updated)
  );

  function automatic logic [255:0] rand256();
    logic [255:0] r = '0;
    for (int i = 0; i < 8; i++) r = {r[223:0], $urandom()};
    return r;
  endfunction

  // Chain of zero length returns its input; otherwise an arbitrary keyed scramble.
  function automatic logic [255:0] chain_fn(input logic [255:0] d, input int s, input int e,
                                            input logic [255:0] a);
    logic [31:0] k;
    if (s == e) return d;
    k = a[95:64] ^ {24'h5A0000, 4'(s), 4'(e)};
    return {d[254:0], d[255]} ^ {8{k}};
  endfunction

  function automatic logic [255:0] upd_fn(input logic [255:0] a, input int e);
    logic [255:0] r = a;
    r[63:32] = {28'hA500000, 4'(e)};
    return r;
  endfunction

  logic [255:0] sig_mem [Len];
  always @(posedge clk) if (sig_mem_rd_en) sig_mem_dout <= sig_mem[sig_mem_rd_addr];

  int gc_cnt = 0;
  int next_lat = 1;
  int lat_lo = 1;
  int lat_hi = 4;
  int gc_s = 0;
  int gc_e = 0;
  logic [255:0] gc_in = '0;
  logic [255:0] gc_a = '0;
  int lat_log[$];

  always @(negedge clk or negedge reset) begin
    if (!reset) begin
      gc_cnt         <= 0;
      gen_chain_done <= 1'b0;
      gen_chain_busy <= 1'b0;
    end else begin
      gen_chain_done <= 1'b0;
      next_lat       <= $urandom_range(lat_hi, lat_lo);
      if (gc_cnt != 0) begin
        gc_cnt <= gc_cnt - 1;
        if (gc_cnt == 1) begin
          gen_chain_done              <= 1'b1;
          gen_chain_busy              <= 1'b0;
          gen_chain_data_out          <= chain_fn(gc_in, gc_s, gc_e, gc_a);
          gen_chain_hash_addr_updated <= upd_fn(gc_a, gc_e);
        end
      end else if (gen_chain_start) begin
        gc_cnt         <= next_lat;
        gen_chain_busy <= 1'b1;
        gc_in          <= gen_chain_input_data;
        gc_s           <= int'(gen_chain_start_step);
        gc_e           <= int'(gen_chain_end_step);
        gc_a           <= gen_chain_hash_addr;
        lat_log.push_back(next_lat);
      end
    end
  end

  int rd_log[$];
  int wr_addr_log[$];
  int ls_log[$];
  int le_log[$];
  logic [255:0] wr_data_log[$];
  logic [255:0] la_log[$];
  int done_cnt = 0;
  int busy_cyc = 0;

  always @(negedge clk) begin
    if (reset) begin
      if (sig_mem_rd_en) rd_log.push_back(int'(sig_mem_rd_addr));
      if (pk_wr_en) begin
        wr_addr_log.push_back(int'(pk_wr_addr));
        wr_data_log.push_back(pk_wr_data);
      end
      if (gen_chain_start) begin
        ls_log.push_back(int'(gen_chain_start_step));
        le_log.push_back(int'(gen_chain_end_step));
        la_log.push_back(gen_chain_hash_addr);
      end
      if (done) done_cnt <= done_cnt + 1;
      if (busy) busy_cyc <= busy_cyc + 1;
    end
  end

  int n_vec = 0;
  int n_err = 0;
  int exp_d[Len];
  bit exp_launch[Len];
  logic [255:0] exp_pk[Len];
  logic [255:0] exp_adrs[Len];

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, ":busy"}, busy, 0);
    chk({tag, ":done"}, done, 0);
    chk({tag, ":hash_addr_out"}, hash_addr_out, 0);
    chk({tag, ":rd_en"}, sig_mem_rd_en, 0);
    chk({tag, ":rd_addr"}, sig_mem_rd_addr, 0);
    chk({tag, ":wr_en"}, pk_wr_en, 0);
    chk({tag, ":wr_addr"}, pk_wr_addr, 0);
    chk({tag, ":wr_data"}, pk_wr_data, 0);
    chk({tag, ":gc_start"}, gen_chain_start, 0);
    chk({tag, ":gc_data"}, gen_chain_input_data, 0);
    chk({tag, ":gc_sstep"}, gen_chain_start_step, 0);
    chk({tag, ":gc_estep"}, gen_chain_end_step, 0);
    chk({tag, ":gc_adrs"}, gen_chain_hash_addr, 0);
  endtask

  // Reference: base-16 digits of the digest, RFC 8391 checksum, chain each element to 15.
  task automatic compute_ref(input logic [255:0] m, input logic [255:0] ha);
    int csum = 0;
    logic [15:0] c16;
    for (int i = 0; i < 64; i++) begin
      exp_d[i] = int'(4'(m >> (252 - 4 * i)));
      csum += 15 - exp_d[i];
    end
    c16 = 16'(csum << 4);
    exp_d[64] = int'(c16[15:12]);
    exp_d[65] = int'(c16[11:8]);
    exp_d[66] = int'(c16[7:4]);
    for (int i = 0; i < Len; i++) begin
      exp_adrs[i] = ha;
      exp_adrs[i][95:64] = 32'(i);
      exp_launch[i] = !(Bypass && exp_d[i] == 15);
      exp_pk[i] = chain_fn(sig_mem[i], exp_d[i], 15, exp_adrs[i]);
    end
  endtask

  task automatic run_op(input string tag, input logic [255:0] m, input bit extra);
    int rd0, wr0, ln0, lt0, dn0, bc0, cyc, k, last, exp_cyc, n_launch;
    logic [255:0] ha, mask, la;
    for (int i = 0; i < Len; i++) sig_mem[i] = rand256();
    ha = rand256();
    pub_seed = rand256();
    compute_ref(m, ha);
    rd0 = rd_log.size(); wr0 = wr_addr_log.size(); ln0 = ls_log.size(); lt0 = lat_log.size();
    dn0 = done_cnt; bc0 = busy_cyc;
    @(negedge clk); start = 1'b1; msg = m; hash_addr = ha;
    @(negedge clk); start = 1'b0; msg = rand256(); hash_addr = rand256();
    if (extra) begin
      repeat (6) @(negedge clk);
      start = 1'b1;
      @(negedge clk); start = 1'b0;
    end
    cyc = 0;
    while (done_cnt == dn0 && cyc < 4000) begin @(negedge clk); cyc++; end
    repeat (3) @(negedge clk);
    chk({tag, ":done_count"}, done_cnt - dn0, 1);
    chk({tag, ":busy_after"}, busy, 0);
    chk({tag, ":read_count"}, rd_log.size() - rd0, Len);
    chk({tag, ":write_count"}, wr_addr_log.size() - wr0, Len);
    for (int i = 0; i < Len; i++) begin
      if (rd0 + i < rd_log.size()) chk({tag, ":rd_addr"}, rd_log[rd0 + i], i);
      if (wr0 + i < wr_addr_log.size()) begin
        chk({tag, ":wr_addr"}, wr_addr_log[wr0 + i], i);
        chk({tag, $sformatf(":pk[%0d]", i)}, wr_data_log[wr0 + i], exp_pk[i]);
      end
    end
    mask = ~(256'hFFFFFFFF << 64);
    k = 0; last = 0; exp_cyc = 0; n_launch = 0;
    for (int i = 0; i < Len; i++) begin
      if (exp_launch[i]) begin
        n_launch++;
        last = i;
        if (ln0 + k < ls_log.size()) begin
          la = la_log[ln0 + k];
          chk({tag, ":chain_field"}, la[95:64], i);
          chk({tag, $sformatf(":start_step[%0d]", i)}, ls_log[ln0 + k], exp_d[i]);
          chk({tag, ":end_step"}, le_log[ln0 + k], 15);
          chk({tag, ":adrs_words"}, la & mask, ha & mask);
          exp_cyc += 4 + lat_log[lt0 + k];
        end
        k++;
      end else begin
        exp_cyc += 3;
      end
    end
    chk({tag, ":launch_count"}, ls_log.size() - ln0, n_launch);
    chk({tag, ":busy_cycles"}, busy_cyc - bc0, exp_cyc);
    chk({tag, ":hash_addr_out"}, hash_addr_out, upd_fn(exp_adrs[last], 15));
    chk({tag, ":input_key"}, gen_chain_input_key, pub_seed);
  endtask

  initial begin
    logic [255:0] m, tmp;
    int base, wr0, dn0, ln0, cyc;
    bit found;

    repeat (3) @(negedge clk);
    check_all_zero("por");
    reset = 1'b1;
    repeat (2) @(negedge clk);

    run_op("msg_zero", '0, 1'b0);
    chk("zero:d64", ls_log[ls_log.size() - 3], 3);
    chk("zero:d65", ls_log[ls_log.size() - 2], 12);
    chk("zero:d66", ls_log[ls_log.size() - 1], 0);

    base = ls_log.size();
    run_op("msg_ones", '1, 1'b0);
    chk("ones:launches", ls_log.size() - base, Bypass ? 3 : 67);

    run_op("rand0", rand256(), 1'b0);
    run_op("rand_restart", rand256(), 1'b1);
    m = '0;
    for (int i = 0; i < 64; i++) m = {m[251:0], ($urandom_range(1, 0) == 1) ? 4'hF : 4'($urandom)};
    run_op("mixed", m, 1'b0);

    // Abort in the middle of chain 10's gen_chain wait.
    lat_lo = 40; lat_hi = 40;
    m = rand256();
    m[215:212] = 4'h3;
    for (int i = 0; i < Len; i++) sig_mem[i] = rand256();
    wr0 = wr_addr_log.size(); dn0 = done_cnt; ln0 = la_log.size();
    @(negedge clk); start = 1'b1; msg = m; hash_addr = rand256();
    @(negedge clk); start = 1'b0;
    found = 1'b0; cyc = 0;
    while (!found && cyc < 3000) begin
      @(negedge clk); cyc++;
      if (la_log.size() > ln0) begin
        tmp = la_log[la_log.size() - 1];
        if (tmp[95:64] == 32'd10) found = 1'b1;
      end
    end
    chk("rst:reached_chain10", found, 1);
    repeat (3) @(negedge clk);
    #2 reset = 1'b0;
    #1 check_all_zero("rst_async");
    chk("rst:writes_before", wr_addr_log.size() - wr0, 10);
    repeat (2) @(negedge clk);
    check_all_zero("rst_hold");
    chk("rst:no_done", done_cnt - dn0, 0);
    chk("rst:no_late_write", wr_addr_log.size() - wr0, 10);
    reset = 1'b1;
    lat_lo = 1; lat_hi = 4;
    repeat (2) @(negedge clk);
    run_op("after_reset", rand256(), 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
